axi_lsu_master: RTL and testbench

MEM-stage load/store unit that turns one data-memory access per instruction into a single AXI4-Lite transaction. It drives `stall_axi` into the hazard unit, which freezes PC, IF/ID and ID/EX while the transaction is in flight. The EX/MEM register is also frozen by `stall_axi`, so the request inputs stay stable until the access completes. It returns sign- or zero-extended load data to the writeback mux.

---
 rtl/axi_lsu_master_pkg.sv | 26 ++
 rtl/lsu_align.sv | 53 +++++
 rtl/axi_lsu_master.sv | 162 ++++++++++++++++
 tb/tb_axi_lsu_master.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lsu_master_pkg.sv
// Shared codes for the MEM-stage AXI4-Lite load/store unit: funct3 access codes,
// AXI response codes and FSM state encodings.
package axi_lsu_master_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WADDR = 3'd1,
        S_WRESP = 3'd2,
        S_RADDR = 3'd3,
        S_RDATA = 3'd4,
        S_DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: store strobes/lane replication, misalignment
// detection and load shift plus sign/zero extension.
module lsu_align
    import axi_lsu_master_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [2:0]          funct3,
    input  logic [1:0]          byte_off,
    input  logic [DATA_W-1:0]   store_data,
    input  logic [DATA_W-1:0]   load_word,
    output logic [DATA_W/8-1:0] wstrb,
    output logic [DATA_W-1:0]   wdata,
    output logic                misaligned,
    output logic [DATA_W-1:0]   load_ext
);
    localparam int NUM_LANES = DATA_W / 8;

    logic [NUM_LANES-1:0][7:0] lanes;
    logic [DATA_W-1:0]         shifted;

    assign misaligned = (funct3[1:0] == F3_LH[1:0] && byte_off[0]) ||
                        (funct3[1:0] == F3_LW[1:0] && byte_off != 2'b00);

    always_comb begin
        case (funct3[1:0])
            F3_SB[1:0]: wstrb = NUM_LANES'(1) << byte_off;
            F3_SH[1:0]: wstrb = NUM_LANES'(3) << byte_off;
            default:    wstrb = '1;
        endcase
    end

    // Narrow stores are copied into every lane so the strobe alone picks the target bytes.
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        assign lanes[i] = (funct3[1:0] == F3_SB[1:0]) ? store_data[7:0] :
                          (funct3[1:0] == F3_SH[1:0]) ? store_data[(i%2)*8 +: 8] :
                                                        store_data[i*8 +: 8];
    end
    assign wdata = lanes;

    assign shifted = load_word >> {byte_off, 3'b000};

    always_comb begin
        case (funct3)
            F3_LB:   load_ext = {{(DATA_W-8){shifted[7]}}, shifted[7:0]};
            F3_LBU:  load_ext = {{(DATA_W-8){1'b0}}, shifted[7:0]};
            F3_LH:   load_ext = {{(DATA_W-16){shifted[15]}}, shifted[15:0]};
            F3_LHU:  load_ext = {{(DATA_W-16){1'b0}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

endmodule

// File: rtl/axi_lsu_master.sv
// MEM-stage load/store unit: one AXI4-Lite transaction per memory instruction,
// stalling the pipeline until the response arrives.
module axi_lsu_master
    import axi_lsu_master_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [31:0]         mem_addr,
    input  logic [31:0]         mem_wdata,
    input  logic [2:0]          funct3,
    output logic [31:0]         load_data,
    output logic                stall_axi,
    output logic                mem_misaligned,
    output logic                mem_bus_err,
    output logic [ADDR_W-1:0]   m_awaddr,
    output logic                m_awvalid,
    input  logic                m_awready,
    output logic [2:0]          m_awprot,
    output logic [DATA_W-1:0]   m_wdata,
    output logic [DATA_W/8-1:0] m_wstrb,
    output logic                m_wvalid,
    input  logic                m_wready,
    input  logic [1:0]          m_bresp,
    input  logic                m_bvalid,
    output logic                m_bready,
    output logic [ADDR_W-1:0]   m_araddr,
    output logic                m_arvalid,
    input  logic                m_arready,
    output logic [2:0]          m_arprot,
    input  logic [DATA_W-1:0]   m_rdata,
    input  logic [1:0]          m_rresp,
    input  logic                m_rvalid,
    output logic                m_rready
);
    state_t            state, state_n;
    logic              aw_done, w_done, aw_done_n, w_done_n;
    logic              awvalid_n, wvalid_n, bready_n, arvalid_n, rready_n;
    logic              aw_fin, w_fin, misaligned;
    logic [DATA_W-1:0] load_ext;

    lsu_align #(.DATA_W(DATA_W)) u_align (
        .funct3     (funct3),
        .byte_off   (mem_addr[1:0]),
        .store_data (mem_wdata),
        .load_word  (m_rdata),
        .wstrb      (m_wstrb),
        .wdata      (m_wdata),
        .misaligned (misaligned),
        .load_ext   (load_ext)
    );

    // Request inputs are frozen by the stall, so payload can come straight from them.
    assign m_awaddr = ADDR_W'({mem_addr[31:2], 2'b00});
    assign m_araddr = ADDR_W'({mem_addr[31:2], 2'b00});
    assign m_awprot = 3'b000;
    assign m_arprot = 3'b000;

    assign aw_fin = aw_done || (m_awvalid && m_awready);
    assign w_fin  = w_done  || (m_wvalid  && m_wready);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (mem_write && !misaligned)     state_n = S_WADDR;
                else if (mem_read && !misaligned) state_n = S_RADDR;
            end
            S_WADDR: if (aw_fin && w_fin)           state_n = S_WRESP;
            S_WRESP: if (m_bvalid && m_bready)      state_n = S_DONE;
            S_RADDR: if (m_arvalid && m_arready)    state_n = S_RDATA;
            S_RDATA: if (m_rvalid && m_rready)      state_n = S_DONE;
            S_DONE:                                 state_n = S_IDLE;
            default:                                state_n = S_IDLE;
        endcase
    end

    always_comb begin
        stall_axi      = 1'b0;
        mem_misaligned = 1'b0;
        mem_bus_err    = 1'b0;
        awvalid_n      = 1'b0;
        wvalid_n       = 1'b0;
        bready_n       = 1'b0;
        arvalid_n      = 1'b0;
        rready_n       = 1'b0;
        aw_done_n      = 1'b0;
        w_done_n       = 1'b0;
        case (state)
            S_IDLE: begin
                stall_axi      = (mem_read || mem_write) && !misaligned;
                mem_misaligned = (mem_read || mem_write) && misaligned;
                awvalid_n      = (state_n == S_WADDR);
                wvalid_n       = (state_n == S_WADDR);
                arvalid_n      = (state_n == S_RADDR);
            end
            S_WADDR: begin
                stall_axi = 1'b1;
                awvalid_n = m_awvalid && !m_awready;
                wvalid_n  = m_wvalid && !m_wready;
                aw_done_n = aw_fin;
                w_done_n  = w_fin;
                bready_n  = aw_fin && w_fin;
            end
            S_WRESP: begin
                stall_axi   = 1'b1;
                bready_n    = !(m_bvalid && m_bready);
                mem_bus_err = m_bvalid && m_bready && (m_bresp != RESP_OKAY);
            end
            S_RADDR: begin
                stall_axi = 1'b1;
                arvalid_n = !m_arready;
                rready_n  = m_arready;
            end
            S_RDATA: begin
                stall_axi   = 1'b1;
                rready_n    = !(m_rvalid && m_rready);
                mem_bus_err = m_rvalid && m_rready && (m_rresp != RESP_OKAY);
            end
            default: ;
        endcase
        // Keep the hazard unit and error flags quiet while reset is held.
        if (rst) begin
            stall_axi      = 1'b0;
            mem_misaligned = 1'b0;
            mem_bus_err    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_awvalid <= 1'b0;
            m_wvalid  <= 1'b0;
            m_bready  <= 1'b0;
            m_arvalid <= 1'b0;
            m_rready  <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
            load_data <= '0;
        end else begin
            m_awvalid <= awvalid_n;
            m_wvalid  <= wvalid_n;
            m_bready  <= bready_n;
            m_arvalid <= arvalid_n;
            m_rready  <= rready_n;
            aw_done   <= aw_done_n;
            w_done    <= w_done_n;
            if (state == S_RDATA && m_rvalid && m_rready)
                load_data <= (m_rresp == RESP_OKAY) ? load_ext : '0;
        end
    end

endmodule

// File: tb/tb_axi_lsu_master.sv
// Randomized bench for axi_lsu_master: latency-programmable AXI4-Lite slave,
// arithmetic reference model and a per-cycle compare process.
module tb_axi_lsu_master;
    import axi_lsu_master_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_read = 1'b0, mem_write = 1'b0;
    logic [31:0] mem_addr = '0, mem_wdata = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] load_data;
    logic        stall_axi, mem_misaligned, mem_bus_err;
    logic [31:0] m_awaddr, m_araddr, m_wdata;
    logic [2:0]  m_awprot, m_arprot;
    logic [3:0]  m_wstrb;
    logic        m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
    logic        m_awready = 1'b0, m_wready = 1'b0, m_bvalid = 1'b0;
    logic        m_arready = 1'b0, m_rvalid = 1'b0;
    logic [1:0]  m_bresp = RESP_OKAY, m_rresp = RESP_OKAY;
    logic [31:0] m_rdata = '0;

    always #5 clk = ~clk;

    axi_lsu_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .funct3(funct3),
        .load_data(load_data), .stall_axi(stall_axi),
        .mem_misaligned(mem_misaligned), .mem_bus_err(mem_bus_err),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awprot(m_awprot),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arprot(m_arprot),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready)
    );

    int total = 0, passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    endtask

    // Reference model: access size in bytes is 1 << funct3[1:0].
    function automatic bit mdl_mis(input logic [2:0] f3, input logic [31:0] a);
        int sz = 1 << f3[1:0];
        return (a % sz) != 0;
    endfunction

    function automatic logic [3:0] mdl_strb(input logic [2:0] f3, input logic [31:0] a);
        int sz = 1 << f3[1:0];
        int off = a % 4;
        logic [3:0] s = '0;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + sz) s[i] = 1'b1;
        return s;
    endfunction

    function automatic logic [31:0] mdl_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = 1 << f3[1:0];
        logic [31:0] r = '0;
        for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'((wd >> (8 * (i % sz))) & 32'hFF);
        return r;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] w);
        int sz = 1 << f3[1:0];
        int off = a % 4;
        longint mask, v;
        if (sz == 4) return w;
        mask = (longint'(1) << (8 * sz)) - 1;
        v = longint'(w >> (8 * off)) & mask;
        if (!f3[2] && v > mask / 2) v = v - (mask + 1);
        return 32'(v);
    endfunction

    // Model state written only by the stimulus process.
    int          phase = 0;  // 0 idle, 1 access in flight, 2 completion cycle
    bit          chk_en = 0, exp_mis = 0;
    logic [31:0] exp_addr = '0, exp_wdata = '0, exp_load = '0;
    logic [3:0]  exp_strb = '0;
    int          aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;

    // Observation counters written only by the compare process.
    int          aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;
    int          aw_vc = 0, w_vc = 0, stall_cnt = 0, err_cnt = 0, mis_cnt = 0;
    logic [31:0] last_awaddr = '0, last_wdata = '0;
    logic [3:0]  last_wstrb = '0;

    // Slave-owned state.
    int aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0, b_prev = 0, r_prev = 0, r_skew = 0;

    always @(posedge clk) begin
        #1;
        if (rst) begin
            m_awready = 0; m_wready = 0; m_bvalid = 0; m_arready = 0; m_rvalid = 0;
            aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
            r_skew = ar_hs - r_hs; r_prev = r_hs; b_prev = b_hs;
        end else begin
            if (m_awvalid) begin m_awready = (aw_cnt >= aw_lat); aw_cnt++; end
            else begin m_awready = 0; aw_cnt = 0; end
            if (m_wvalid) begin m_wready = (w_cnt >= w_lat); w_cnt++; end
            else begin m_wready = 0; w_cnt = 0; end
            if (m_arvalid) begin m_arready = (ar_cnt >= ar_lat); ar_cnt++; end
            else begin m_arready = 0; ar_cnt = 0; end
            if (m_bvalid) begin
                if (b_hs != b_prev) begin m_bvalid = 0; b_prev = b_hs; end
            end else if (aw_hs > b_hs && w_hs > b_hs) begin
                if (b_cnt >= b_lat) begin m_bvalid = 1; b_cnt = 0; end else b_cnt++;
            end
            if (m_rvalid) begin
                if (r_hs != r_prev) begin m_rvalid = 0; r_prev = r_hs; end
            end else if (ar_hs > r_hs + r_skew) begin
                if (r_cnt >= r_lat) begin m_rvalid = 1; r_cnt = 0; end else r_cnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (m_awvalid && m_awready) aw_hs++;
            if (m_wvalid && m_wready)   w_hs++;
            if (m_bvalid && m_bready)   b_hs++;
            if (m_arvalid && m_arready) ar_hs++;
            if (m_rvalid && m_rready)   r_hs++;
            if (m_awvalid) begin aw_vc++; last_awaddr = m_awaddr; end
            if (m_wvalid) begin w_vc++; last_wstrb = m_wstrb; last_wdata = m_wdata; end
            if (stall_axi) stall_cnt++;
            if (mem_bus_err) err_cnt++;
            if (mem_misaligned) mis_cnt++;
            if (chk_en) begin
                check("stall", stall_axi, phase == 1);
                check("misaligned", mem_misaligned, exp_mis);
                check("bus_err", mem_bus_err,
                      (m_bvalid && m_bready && m_bresp != RESP_OKAY) ||
                      (m_rvalid && m_rready && m_rresp != RESP_OKAY));
                check("load_data", load_data, exp_load);
                if (phase != 1)
                    check("quiet_bus", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
                if (m_awvalid) begin
                    check("awaddr", m_awaddr, exp_addr);
                    check("awprot", m_awprot, 0);
                end
                if (m_wvalid) begin
                    check("wstrb", m_wstrb, exp_strb);
                    check("wdata", m_wdata, exp_wdata);
                end
                if (m_arvalid) begin
                    check("araddr", m_araddr, exp_addr);
                    check("arprot", m_arprot, 0);
                end
            end
        end
    end

    int d_aw_vc, d_w_vc, d_stall, d_err, d_mis;

    task automatic run_op(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] rd, input logic [1:0] resp,
                          input int awl, input int wl, input int bl, input int arl, input int rl);
        int b_aw = aw_hs, b_w = w_hs, b_b = b_hs, b_ar = ar_hs, b_r = r_hs;
        int s_aw = aw_vc, s_w = w_vc, s_st = stall_cnt, s_er = err_cnt, s_mi = mis_cnt;
        int base_done = b_hs + r_hs;
        int cyc = 0;
        bit mis = mdl_mis(f3, addr);
        aw_lat = awl; w_lat = wl; b_lat = bl; ar_lat = arl; r_lat = rl;
        m_bresp = resp; m_rresp = resp; m_rdata = rd;
        exp_addr = addr & ~32'h3;
        exp_strb = mdl_strb(f3, addr);
        exp_wdata = mdl_wdata(f3, wd);
        mem_write = wr; mem_read = !wr; funct3 = f3; mem_addr = addr; mem_wdata = wd;
        if (mis) begin
            exp_mis = 1;
            @(posedge clk); #2;
            exp_mis = 0;
        end else begin
            phase = 1;
            while ((b_hs + r_hs) == base_done && cyc < 200) begin
                @(posedge clk); #2;
                cyc++;
            end
            check("op_timeout", cyc < 200, 1);
            if (!wr) exp_load = (resp == RESP_OKAY) ? mdl_load(f3, addr, rd) : 32'h0;
            phase = 2;
            @(posedge clk); #2;
        end
        mem_write = 0; mem_read = 0; phase = 0;
        check("handshakes", (aw_hs - b_aw) * 10000 + (w_hs - b_w) * 1000 + (b_hs - b_b) * 100 +
                            (ar_hs - b_ar) * 10 + (r_hs - b_r),
              mis ? 0 : (wr ? 11100 : 11));
        d_aw_vc = aw_vc - s_aw; d_w_vc = w_vc - s_w; d_stall = stall_cnt - s_st;
        d_err = err_cnt - s_er; d_mis = mis_cnt - s_mi;
        @(posedge clk); #2;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;
        repeat (2) @(posedge clk);
        #2;
        check("rst_load_data", load_data, 0);
        check("rst_stall", stall_axi, 0);
        check("rst_valids", {m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready}, 0);
        check("rst_pulses", {mem_bus_err, mem_misaligned}, 0);
        rst = 0; chk_en = 1;
        @(posedge clk); #2;

        run_op(1, F3_SW, 32'h1004, 32'hDEADBEEF, 0, RESP_OKAY, 0, 0, 0, 0, 0);
        check("sw_awaddr", last_awaddr, 32'h1004);
        check("sw_wstrb", last_wstrb, 4'hF);
        check("sw_wdata", last_wdata, 32'hDEADBEEF);
        check("sw_stall_cycles", d_stall, 3);

        run_op(1, F3_SB, 32'h1003, 32'h000000A5, 0, RESP_OKAY, 0, 0, 0, 0, 0);
        check("sb_wstrb", last_wstrb, 4'b1000);
        check("sb_wdata", last_wdata, 32'hA5A5A5A5);

        run_op(0, F3_LB, 32'h2001, 0, 32'h000080FF, RESP_OKAY, 0, 0, 0, 0, 0);
        check("lb_load", load_data, 32'hFFFFFF80);
        check("lb_stall_cycles", d_stall, 3);
        run_op(0, F3_LBU, 32'h2001, 0, 32'h000080FF, RESP_OKAY, 0, 0, 0, 0, 0);
        check("lbu_load", load_data, 32'h00000080);

        run_op(1, F3_SW, 32'h1008, 32'h12345678, 0, RESP_OKAY, 3, 0, 0, 0, 0);
        check("slow_aw_awvalid_cycles", d_aw_vc, 4);
        check("slow_aw_wvalid_cycles", d_w_vc, 1);

        run_op(0, F3_LW, 32'h3000, 0, 32'hCAFEF00D, RESP_SLVERR, 0, 0, 0, 0, 0);
        check("slverr_pulses", d_err, 1);
        check("slverr_load", load_data, 0);
        check("slverr_stall_cycles", d_stall, 3);

        run_op(0, F3_LH, 32'h4001, 0, 32'h11112222, RESP_OKAY, 0, 0, 0, 0, 0);
        check("mis_pulses", d_mis, 1);
        check("mis_stall_cycles", d_stall, 0);

        for (int n = 0; n < 60; n++) begin
            bit          wr = $urandom_range(0, 1) == 1;
            logic [2:0]  f3;
            logic [31:0] a = $urandom;
            int          pick = $urandom_range(0, 4);
            if (wr) f3 = (pick > 2) ? F3_SW : 3'(pick);
            else    f3 = (pick == 3) ? F3_LBU : (pick == 4) ? F3_LHU : 3'(pick);
            if ($urandom_range(0, 3) != 0) a = a & ~((32'h1 << f3[1:0]) - 1);
            run_op(wr, f3, a, $urandom, $urandom,
                   ($urandom_range(0, 3) == 0) ? RESP_SLVERR : RESP_OKAY,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2),
                   $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Reset while a read is waiting in the data phase.
        aw_lat = 0; w_lat = 0; b_lat = 0; ar_lat = 0; r_lat = 6;
        m_rresp = RESP_OKAY; m_rdata = 32'h55AA55AA;
        exp_addr = 32'h5000;
        mem_read = 1; funct3 = F3_LW; mem_addr = 32'h5000; phase = 1;
        cyc = 0;
        while (!m_rready && cyc < 20) begin @(posedge clk); #2; cyc++; end
        check("rdata_phase_reached", m_rready, 1);
        #1;
        chk_en = 0; rst = 1;
        #1;
        check("rst_mid_rready", m_rready, 0);
        check("rst_mid_stall", stall_axi, 0);
        check("rst_mid_arvalid", m_arvalid, 0);
        mem_read = 0; phase = 0; exp_load = 0;
        repeat (2) @(posedge clk);
        #2;
        rst = 0; chk_en = 1;
        repeat (3) @(posedge clk);
        #2;
        run_op(0, F3_LW, 32'h6000, 0, 32'h0BADF00D, RESP_OKAY, 0, 0, 0, 0, 0);
        check("post_rst_load", load_data, 32'h0BADF00D);
        check("post_rst_stall_cycles", d_stall, 3);
        run_op(1, F3_SH, 32'h6002, 32'h0000BEEF, 0, RESP_OKAY, 1, 2, 1, 0, 0);
        check("post_rst_sh_wstrb", last_wstrb, 4'b1100);
        check("post_rst_sh_wdata", last_wdata, 32'hBEEFBEEF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
